// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / stall controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_HALT     = 3'd4
    } state_t;

    // Cycles spent flushing the pipe after run drops.
    localparam int DRAIN_CYCLES = 4;
    localparam int DRAIN_W      = 3;

    // Register x0 is hardwired to zero, so it never creates a real dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Stage-register control bundle driven by the output decode.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_bubble;
    } stage_ctrl_t;

    // Everything frozen: idle, halted, or waiting on data memory.
    localparam stage_ctrl_t CTRL_HOLD  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // Normal flow: every stage advances, nothing squashed.
    localparam stage_ctrl_t CTRL_FLOW  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    // Drain: stop fetching, inject NOPs, let older instructions retire.
    localparam stage_ctrl_t CTRL_DRAIN = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector: flags an ID instruction reading the load in EX.
// Latency: purely combinational, same cycle.
// Backpressure: none; the controller decides whether the flag is acted on.
module pipe_hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       load_use
);

    // A load into x0 produces nothing to wait for, so it never stalls.
    assign load_use = ex_memread
                   && (ex_rd != REG_ZERO)
                   && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: run/drain/halt FSM, stall and flush decode, perf counters.
// Latency: stage enables/flush/bubble are combinational (same cycle); state, err, counters registered.
// Backpressure: a data-memory miss freezes every stage until dmem_ready or the wait timeout.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
)
(
    input  logic             clk,
    input  logic             arst_n,
    input  logic             run,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    // Last stalled cycle before giving up on the memory.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [DRAIN_W-1:0]  drain_cnt;
    stage_ctrl_t         ctrl;
    logic                load_use;
    logic                mem_stall;
    logic                flow_cycle;
    logic                branch_flush;

    pipe_hazard_detect u_hazard (
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .load_use   (load_use)
    );

    assign mem_stall  = dmem_req && !dmem_ready;
    // Cycles where the pipe flows normally: RUN without a miss, or the
    // MEM_WAIT cycle in which the outstanding access completes.
    assign flow_cycle = ((state == ST_RUN) && !mem_stall)
                     || ((state == ST_MEM_WAIT) && dmem_ready);

    // Output decode: memory stall beats branch, branch beats load-use.
    always_comb begin
        ctrl         = CTRL_HOLD;
        branch_flush = 1'b0;
        if (flow_cycle) begin
            ctrl = CTRL_FLOW;
            if (branch_taken) begin
                ctrl.if_id_flush  = 1'b1;
                ctrl.id_ex_bubble = 1'b1;
                branch_flush      = 1'b1;
            end else if (load_use) begin
                ctrl.pc_en        = 1'b0;
                ctrl.if_id_en     = 1'b0;
                ctrl.id_ex_bubble = 1'b1;
            end
        end else if ((state == ST_DRAIN) && !mem_stall) begin
            ctrl = CTRL_DRAIN;
        end
    end

    assign pc_en        = ctrl.pc_en;
    assign if_id_en     = ctrl.if_id_en;
    assign id_ex_en     = ctrl.id_ex_en;
    assign ex_mem_en    = ctrl.ex_mem_en;
    assign mem_wb_en    = ctrl.mem_wb_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_bubble = ctrl.id_ex_bubble;
    assign busy         = (state != ST_IDLE);

    // Controller FSM with its wait and drain counters and the sticky error flag.
    // In DRAIN the wait counter tracks consecutive stalled cycles and is
    // cleared by any cycle in which the memory is not stalling.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state     <= ST_IDLE;
            err       <= 1'b0;
            wait_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (mem_stall) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= '0;
                    end else if (!run) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
                        wait_cnt  <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ready) begin
                        state <= ST_RUN;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                        if (wait_cnt == WAIT_LAST) begin
                            state <= ST_HALT;
                            err   <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (mem_stall) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                        if (wait_cnt == WAIT_LAST) begin
                            state <= ST_HALT;
                            err   <= 1'b1;
                        end
                    end else begin
                        wait_cnt  <= '0;
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                        if (drain_cnt == DRAIN_W'(1)) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating performance counters: frozen-fetch cycles and branch flushes.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (busy && !pc_en && (state != ST_DRAIN) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (branch_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed table, corner sequences, random vs reference model.
// Latency: inputs applied on the falling edge, outputs sampled 1 ns later.
// Backpressure: exercised through dmem_req/dmem_ready stall patterns and timeouts.
module tb_pipeline_ctrl;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic             clk;
    logic             arst_n;
    logic             run;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       ex_rd;
    logic             ex_memread;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    pipeline_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .run          (run),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .ex_rd        (ex_rd),
        .ex_memread   (ex_memread),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en    (mem_wb_en),
        .if_id_flush  (if_id_flush),
        .id_ex_bubble (id_ex_bubble),
        .busy         (busy),
        .err          (err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Sampled outputs: [16:10] enables/flush/bubble, [9] busy, [8] err, [7:4] stall, [3:0] flush.
    logic [31:0] act;

    // Reference model: mode 0 idle, 1 running, 2 waiting on memory, 3 draining, 4 halted.
    int m_mode, m_waited, m_drain_left, m_stall, m_flush;
    bit m_err;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_waited = 0; m_drain_left = 0; m_stall = 0; m_flush = 0; m_err = 0;
    endtask

    // Predicts outputs for the current inputs, then advances the model by one clock.
    task automatic model_cycle(input logic rst, r, input logic [4:0] rs1, rs2, rd,
                               input logic mr, br, dq, dy, output logic [31:0] e);
        bit hazard, mstall, active, pc, ifid, fl, bub, drain_out;
        logic [6:0] c;
        hazard    = mr && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
        mstall    = dq && !dy;
        active    = (m_mode == 1 && !mstall) || (m_mode == 2 && dy);
        drain_out = (m_mode == 3) && !mstall;
        pc   = active && (br || !hazard);
        ifid = active && (br || !hazard);
        fl   = active && br;
        bub  = active && (br || hazard);
        if (active)         c = {pc, ifid, 3'b111, fl, bub};
        else if (drain_out) c = 7'b0111111;
        else                c = 7'b0000000;
        e = '0;
        e[16:10] = c;
        e[9]     = (m_mode != 0);
        e[8]     = m_err;
        e[7:4]   = m_stall[3:0];
        e[3:0]   = m_flush[3:0];

        if (!rst) begin
            model_reset();
        end else begin
            if (m_mode != 0 && m_mode != 3 && !c[6]) m_stall = (m_stall < MAXC) ? m_stall + 1 : MAXC;
            if (fl) m_flush = (m_flush < MAXC) ? m_flush + 1 : MAXC;
            case (m_mode)
                0: if (r) m_mode = 1;
                1: begin
                    if (mstall) begin m_mode = 2; m_waited = 0; end
                    else if (!r) begin m_mode = 3; m_drain_left = 4; m_waited = 0; end
                end
                2: begin
                    if (dy) m_mode = 1;
                    else begin
                        m_waited++;
                        if (m_waited == TIMEOUT) begin m_mode = 4; m_err = 1; end
                    end
                end
                3: begin
                    if (mstall) begin
                        m_waited++;
                        if (m_waited == TIMEOUT) begin m_mode = 4; m_err = 1; end
                    end else begin
                        m_waited = 0;
                        m_drain_left--;
                        if (m_drain_left == 0) m_mode = 0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // One clock: drive on the falling edge, sample 1 ns later, compare to the model.
    task automatic step(input logic rst, r, input logic [4:0] rs1, rs2, rd,
                        input logic mr, br, dq, dy, input string nm);
        logic [31:0] e;
        @(negedge clk);
        arst_n = rst; run = r; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
        ex_memread = mr; branch_taken = br; dmem_req = dq; dmem_ready = dy;
        #1;
        act = {15'b0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
               id_ex_bubble, busy, err, stall_cnt, flush_cnt};
        model_cycle(rst, r, rs1, rs2, rd, mr, br, dq, dy, e);
        check({nm, "_model"}, act, e);
    endtask

    task automatic plain(input logic r, input string nm);
        step(1'b1, r, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, nm);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
    endtask

    typedef struct {
        string      nm;
        logic       rst, r;
        logic [4:0] rs1, rs2, rd;
        logic       mr, br, dq, dy;
        logic [6:0] ctrl;
        logic       bsy;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic rst, r, input logic [4:0] rs1, rs2, rd,
                                input logic mr, br, dq, dy, input logic [6:0] ctrl, input logic bsy);
        vec_t v;
        v.nm = nm; v.rst = rst; v.r = r; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.mr = mr; v.br = br; v.dq = dq; v.dy = dy; v.ctrl = ctrl; v.bsy = bsy;
        return v;
    endfunction

    vec_t tbl[18];

    initial begin
        int n;
        // ctrl order: pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble
        tbl[0]  = mk("rst_wins",    0, 1, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0);
        tbl[1]  = mk("idle",        1, 1, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0);
        tbl[2]  = mk("run",         1, 1, 1, 2, 3, 0, 0, 0, 0, 7'b1111100, 1);
        tbl[3]  = mk("load_use",    1, 1, 1, 5, 5, 1, 0, 0, 0, 7'b0011101, 1);
        tbl[4]  = mk("after_lu",    1, 1, 1, 2, 3, 0, 0, 0, 0, 7'b1111100, 1);
        tbl[5]  = mk("lu_x0",       1, 1, 0, 0, 0, 1, 0, 0, 0, 7'b1111100, 1);
        tbl[6]  = mk("br_over_lu",  1, 1, 7, 1, 7, 1, 1, 0, 0, 7'b1111111, 1);
        tbl[7]  = mk("miss_run",    1, 1, 7, 1, 7, 1, 1, 1, 0, 7'b0000000, 1);
        tbl[8]  = mk("miss_w1",     1, 1, 1, 2, 3, 0, 0, 1, 0, 7'b0000000, 1);
        tbl[9]  = mk("miss_w2",     1, 1, 1, 2, 3, 0, 0, 1, 0, 7'b0000000, 1);
        tbl[10] = mk("miss_done",   1, 1, 1, 2, 3, 0, 0, 1, 1, 7'b1111100, 1);
        tbl[11] = mk("back_run",    1, 1, 1, 2, 3, 0, 0, 0, 0, 7'b1111100, 1);
        tbl[12] = mk("run_drop",    1, 0, 1, 2, 3, 0, 0, 0, 0, 7'b1111100, 1);
        tbl[13] = mk("drain1",      1, 1, 1, 2, 3, 0, 0, 0, 0, 7'b0111111, 1);
        tbl[14] = mk("drain2",      1, 1, 1, 2, 3, 0, 0, 0, 0, 7'b0111111, 1);
        tbl[15] = mk("drain3",      1, 1, 1, 2, 3, 0, 0, 0, 0, 7'b0111111, 1);
        tbl[16] = mk("drain4",      1, 1, 1, 2, 3, 0, 0, 0, 0, 7'b0111111, 1);
        tbl[17] = mk("idle_again",  1, 0, 1, 2, 3, 0, 0, 0, 0, 7'b0000000, 0);

        arst_n = 1'b0; run = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        ex_memread = 1'b0; branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();

        // Directed table.
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].rst, tbl[i].r, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
                 tbl[i].mr, tbl[i].br, tbl[i].dq, tbl[i].dy, tbl[i].nm);
            check(tbl[i].nm, {22'b0, act[16:9]}, {22'b0, tbl[i].ctrl, tbl[i].bsy});
            if (i == 4) check("stall_cnt_lu", {28'b0, act[7:4]}, 32'd1);
            if (i == 10) check("flush_cnt_br", {28'b0, act[3:0]}, 32'd1);
        end
        // Load-use (1) + miss in RUN (1) + two frozen MEM_WAIT cycles (2); drain not counted.
        check("stall_cnt_total", {28'b0, act[7:4]}, 32'd4);

        // Memory timeout: stalled cycles before err shows = RUN miss cycle + TIMEOUT waits.
        do_reset();
        plain(1'b1, "to_idle");
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, "to_wait");
            if (act[8]) break;
            n++;
        end
        check("timeout_cycles", n, TIMEOUT + 1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, i[0], 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, "halt_hold");
        end
        check("halt_sticky", {22'b0, act[16:8]}, {22'b0, 7'b0, 1'b1, 1'b1});
        do_reset();
        plain(1'b0, "post_halt");
        check("reset_after_halt", act, 32'd0);

        // Drain paused by a memory miss, then resumes its remaining cycles.
        plain(1'b1, "dr_idle");
        plain(1'b0, "dr_run");
        plain(1'b1, "dr_first");
        check("drain_first", {25'b0, act[16:10]}, {25'b0, 7'b0111111});
        step(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, "dr_miss");
        check("drain_miss", {25'b0, act[16:10]}, 32'd0);
        step(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, "dr_miss");
        n = 0;
        for (int i = 0; i < 10; i++) begin
            plain(1'b1, "dr_rest");
            if (!act[9]) break;
            n++;
        end
        check("drain_remaining", n, 3);

        // Reset during MEM_WAIT.
        plain(1'b1, "rw_idle");
        step(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, "rw_miss");
        step(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, "rw_wait");
        do_reset();
        plain(1'b0, "rw_after");
        check("reset_in_wait", act, 32'd0);

        // Stall counter saturation.
        plain(1'b1, "sat_idle");
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 5'd9, 5'd4, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, "sat_lu");
        end
        plain(1'b1, "sat_chk");
        check("stall_saturate", {28'b0, act[7:4]}, MAXC);

        // Random traffic against the model; second half starves memory to reach timeouts.
        for (int i = 0; i < 3000; i++) begin
            logic rr, mm, bb, dq, dy, rs;
            rs = ($urandom_range(0, 63) != 0);
            rr = ($urandom_range(0, 7) != 0);
            mm = $urandom_range(0, 1) == 1;
            bb = ($urandom_range(0, 3) == 0);
            dq = ($urandom_range(0, 2) == 0);
            dy = (i < 1500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            step(rs, rr, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), mm, bb, dq, dy, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The parameter list SHALL be: TIMEOUT, default 255, maximum MEM_WAIT cycles before error; CNT_W, default 16, performance counter width.
REQ-002 The ports SHALL be, in this order:
- clk  in  1  sole clock; all state updates on its rising edge.
- arst_n  in  1  reset; synchronous, active-low.
- run  in  1  core run request.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in IF/ID.
- ex_rd  in  5  destination register of the instruction in ID/EX.
- ex_memread  in  1  the ID/EX instruction is a load.
- branch_taken  in  1  EX resolved a taken branch or jump.
- dmem_req  in  1  the EX/MEM instruction accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage-register enables.
- if_id_flush  out  1  load a NOP into IF/ID.
- id_ex_bubble  out  1  zero the ID/EX control fields.
- busy  out  1  state is not IDLE.
- err  out  1  sticky memory-timeout flag.
- stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters.

Function
REQ-003 The FSM SHALL have five states: IDLE, RUN, MEM_WAIT, DRAIN, HALT. State is registered; enables, flush and bubble are combinational from state and inputs, so they act in the same cycle.
REQ-004 In IDLE and HALT, all enables, if_id_flush and id_ex_bubble SHALL be 0.
REQ-005 IDLE SHALL go to RUN on the edge where run=1.
REQ-006 In RUN, the defaults SHALL be: all enables 1, flush 0, bubble 0.
REQ-007 Load-use: when ex_memread=1, ex_rd!=0 and ex_rd equals id_rs1 or id_rs2, the block SHALL drive pc_en=0, if_id_en=0 and id_ex_bubble=1 for that cycle only.
REQ-008 On branch_taken=1 in RUN, the block SHALL drive if_id_flush=1 and id_ex_bubble=1 with pc_en=1. A branch SHALL override a load-use stall in the same cycle.
REQ-009 On dmem_req=1 with dmem_ready=0 in RUN, the block SHALL drive all enables, flush and bubble to 0 and go to MEM_WAIT. This rule SHALL override REQ-007 and REQ-008.
REQ-010 In MEM_WAIT with dmem_ready=0, all outputs SHALL be held as in REQ-004, and the wait counter SHALL increment.
REQ-011 In MEM_WAIT, the cycle in which dmem_ready=1 SHALL behave as RUN under REQ-006 to REQ-008, and the next state SHALL be RUN.
REQ-012 When the wait counter reaches TIMEOUT, the FSM SHALL go to HALT and err SHALL be set.
REQ-013 On entering MEM_WAIT, the wait counter SHALL clear.
REQ-014 When run=0 in RUN with no pending memory stall, the FSM SHALL go to DRAIN and the drain counter SHALL load 4.
REQ-015 In DRAIN, the block SHALL drive pc_en=0, if_id_flush=1 and id_ex_bubble=1, with the remaining enables at 1.
REQ-016 In DRAIN, the drain counter SHALL decrement each cycle. It SHALL go to IDLE after the cycle in which it reaches 0.
REQ-017 During DRAIN, the memory stall of REQ-009 SHALL still apply: all enables 0 and the drain counter paused, without leaving DRAIN. The MEM_WAIT timeout SHALL also apply.
REQ-018 A run=1 seen during DRAIN SHALL be ignored until the FSM reaches IDLE.
REQ-019 stall_cnt SHALL increment on each cycle where busy=1 and pc_en=0, excluding DRAIN. It SHALL saturate at all-ones.
REQ-020 flush_cnt SHALL increment on each cycle where a branch flush is applied. It SHALL saturate at all-ones.
REQ-021 HALT SHALL be exited only by reset.

Reset
REQ-022 When arst_n=0 at a clk edge, the block SHALL go to IDLE.
REQ-023 Reset SHALL clear err, both counters, the wait counter and the drain counter.
REQ-024 Reset SHALL override every other event, including reset during MEM_WAIT or DRAIN.
REQ-025 After reset, all outputs SHALL be 0.

Structure
REQ-026 A shared package, pipeline_ctrl_pkg, SHALL hold the state encoding, DRAIN_CYCLES=4 and REG_ZERO=5'd0.
REQ-027 Load-use comparison SHALL live in a combinational sub-module, pipe_hazard_detect.
REQ-028 The FSM, the counters and the output decode SHALL live in pipeline_ctrl.

Verification
REQ-029 Reset, then run=1 -> busy=1 on the next cycle and all enables 1.
REQ-030 ex_memread=1, ex_rd=5, id_rs2=5 for one cycle -> pc_en=0, if_id_en=0, id_ex_bubble=1 for that cycle, and stall_cnt=1.
REQ-031 Same as REQ-030 with ex_rd=0 -> no stall.
REQ-032 branch_taken=1 together with the load-use condition -> if_id_flush=1, pc_en=1, flush_cnt=1.
REQ-033 dmem_req=1 with dmem_ready=0 for 3 cycles, then 1 -> enables 0 for 3 cycles, 1 on the fourth, state RUN afterwards.
REQ-034 TIMEOUT=8 and dmem_ready held at 0 -> err=1 and HALT; run toggling keeps HALT; reset returns IDLE with err=0.
REQ-035 run=0 in RUN -> 4 DRAIN cycles with pc_en=0, then IDLE with busy=0.
